// File: rtl/mips_pkg.sv
// mips_pkg: shared opcode/funct constants, FSM states and decoded-op bundle
// for the multi-cycle MIPS subset core.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL,
        ALU_LUI
    } alu_op_t;

    typedef struct packed {
        alu_op_t    op;
        logic       illegal;
        logic       trap_ovf;
        logic       use_imm;
        logic       zext;
        logic       is_lw;
        logic       is_sw;
        logic       wen;
        logic [4:0] dst;
    } dec_t;

endpackage

// File: rtl/mips_alu.sv
// mips_alu: combinational arithmetic/logic/shift unit with signed
// overflow detection for add and sub.
module mips_alu
    import mips_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  shamt,
    input  alu_op_t     op,
    output logic [31:0] result,
    output logic        ovf
);

    logic [31:0] sum;
    logic [31:0] dif;

    assign sum = a + b;
    assign dif = a - b;

    // Select the result; overflow only meaningful for add/sub.
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        unique case (op)
            ALU_ADD: begin
                result = sum;
                ovf    = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            ALU_SUB: begin
                result = dif;
                ovf    = (a[31] != b[31]) && (dif[31] != a[31]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {31'b0, $signed(a) < $signed(b)};
            ALU_SLL: result = b << shamt;
            ALU_SRL: result = b >> shamt;
            ALU_LUI: result = {b[15:0], 16'b0};
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_core.sv
// mips_mc_core: multi-cycle MIPS subset core, one instruction in flight.
// Define MIPS_OVF_TRAP_EN to trap signed overflow in add/addi/sub.
module mips_mc_core
    import mips_pkg::*;
#(
    parameter int NUM_GPR    = 32,
    parameter int DMEM_DEPTH = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                instruction,
    input  logic                       instr_valid,
    output logic                       instr_ready,
    output logic                       done,
    output logic                       err_illegal,
    output logic                       err_align,
    input  logic [$clog2(NUM_GPR)-1:0] dbg_reg_sel,
    output logic [31:0]                dbg_reg_data
);

    localparam int RW = $clog2(NUM_GPR);
    localparam int AW = $clog2(DMEM_DEPTH);

    state_t      state;
    logic [31:0] ir;
    dec_t        dec;
    dec_t        dn;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] res;
    logic        ovf;
    logic [31:0] ld;
    logic [31:0] alu_res;
    logic        alu_ovf;
    logic        trap;
    logic        misalign;
    logic        wb_ok;

    logic [31:0] gpr  [NUM_GPR];
    logic [31:0] dmem [DMEM_DEPTH];

    logic [5:0]  opc;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  fn;
    logic [31:0] simm;
    logic [31:0] zimm;
    logic [AW-1:0] widx;

    assign opc  = ir[31:26];
    assign rs   = ir[25:21];
    assign rt   = ir[20:16];
    assign rd   = ir[15:11];
    assign fn   = ir[5:0];
    assign simm = {{16{ir[15]}}, ir[15:0]};
    assign zimm = {16'b0, ir[15:0]};
    assign widx = res[AW+1:2];

    assign dbg_reg_data = gpr[dbg_reg_sel];
    assign misalign     = res[1:0] != 2'b00;

`ifdef MIPS_OVF_TRAP_EN
    assign trap = dec.trap_ovf && ovf;
`else
    assign trap = 1'b0;
`endif

    assign wb_ok = !dec.illegal && !trap && dec.wen && (dec.dst != 5'd0)
                && !((dec.is_lw || dec.is_sw) && misalign);

    mips_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .shamt  (ir[10:6]),
        .op     (dec.op),
        .result (alu_res),
        .ovf    (alu_ovf)
    );

    // Decode the captured instruction word into the op bundle.
    always_comb begin
        dn     = '0;
        dn.op  = ALU_ADD;
        dn.wen = 1'b1;
        dn.dst = rt;
        unique case (opc)
            OP_RTYPE: begin
                dn.dst = rd;
                unique case (fn)
                    FN_ADD:  begin dn.op = ALU_ADD; dn.trap_ovf = 1'b1; end
                    FN_ADDU: dn.op = ALU_ADD;
                    FN_SUB:  begin dn.op = ALU_SUB; dn.trap_ovf = 1'b1; end
                    FN_AND:  dn.op = ALU_AND;
                    FN_OR:   dn.op = ALU_OR;
                    FN_SLT:  dn.op = ALU_SLT;
                    FN_SLL:  dn.op = ALU_SLL;
                    FN_SRL:  dn.op = ALU_SRL;
                    default: dn.illegal = 1'b1;
                endcase
            end
            OP_ADDI:  begin dn.use_imm = 1'b1; dn.trap_ovf = 1'b1; end
            OP_ADDIU: dn.use_imm = 1'b1;
            OP_ANDI:  begin dn.use_imm = 1'b1; dn.zext = 1'b1; dn.op = ALU_AND; end
            OP_ORI:   begin dn.use_imm = 1'b1; dn.zext = 1'b1; dn.op = ALU_OR; end
            OP_LUI:   begin dn.use_imm = 1'b1; dn.zext = 1'b1; dn.op = ALU_LUI; end
            OP_LW:    begin dn.use_imm = 1'b1; dn.is_lw = 1'b1; end
            OP_SW:    begin dn.use_imm = 1'b1; dn.is_sw = 1'b1; dn.wen = 1'b0; end
            default:  dn.illegal = 1'b1;
        endcase
        if (int'(rs) >= NUM_GPR || int'(rt) >= NUM_GPR
            || (opc == OP_RTYPE && int'(rd) >= NUM_GPR))
            dn.illegal = 1'b1;
    end

    // Sequencer, register file and data memory; all writes happen here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            instr_ready <= 1'b1;
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_align   <= 1'b0;
            ir          <= '0;
            dec         <= '0;
            op_a        <= '0;
            op_b        <= '0;
            res         <= '0;
            ovf         <= 1'b0;
            ld          <= '0;
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
        end else begin
            done        <= 1'b0;
            err_illegal <= 1'b0;
            err_align   <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (instr_valid) begin
                        ir          <= instruction;
                        instr_ready <= 1'b0;
                        state       <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    dec   <= dn;
                    op_a  <= gpr[rs[RW-1:0]];
                    op_b  <= dn.use_imm ? (dn.zext ? zimm : simm)
                                        : gpr[rt[RW-1:0]];
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    res <= alu_res;
                    ovf <= alu_ovf;
                    if (!dec.illegal && (dec.is_lw || dec.is_sw))
                        state <= S_MEM;
                    else
                        state <= S_WB;
                end
                S_MEM: begin
                    if (dec.is_sw && !misalign)
                        dmem[widx] <= gpr[rt[RW-1:0]];
                    ld    <= dmem[widx];
                    state <= S_WB;
                end
                S_WB: begin
                    if (wb_ok)
                        gpr[dec.dst[RW-1:0]] <= dec.is_lw ? ld : res;
                    done        <= 1'b1;
                    err_illegal <= dec.illegal || trap;
                    err_align   <= !dec.illegal && misalign
                                && (dec.is_lw || dec.is_sw);
                    instr_ready <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mips_mc_core.md
MIPS_MC_CORE -- requirements
Module: mips_mc_core

Interface
REQ-001 SHALL have parameter NUM_GPR, default 32, number of general-purpose registers (power of two, 8..32).
REQ-002 SHALL have parameter DMEM_DEPTH, default 256, number of 32-bit words in data memory (power of two).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port instruction  input  32  MIPS instruction word.
REQ-006 SHALL have port instr_valid  input  1  instruction is presented.
REQ-007 SHALL have port instr_ready  output  1  core accepts an instruction this cycle.
REQ-008 SHALL have port done  output  1  one-cycle pulse, instruction retired.
REQ-009 SHALL have port err_illegal  output  1  one-cycle pulse with done, unsupported opcode/funct.
REQ-010 SHALL have port err_align  output  1  one-cycle pulse with done, lw/sw address low 2 bits nonzero.
REQ-011 SHALL have port dbg_reg_sel  input  $clog2(NUM_GPR)  debug register index.
REQ-012 SHALL have port dbg_reg_data  output  32  combinational read of GPR[dbg_reg_sel].

Function
REQ-013 SHALL implement FSM IDLE -> DECODE -> EXEC -> [MEM for lw/sw] -> WB -> IDLE.
REQ-014 SHALL drive instr_ready=1 only in IDLE; instruction captured when instr_valid && instr_ready; instruction input ignored in all other states.
REQ-015 SHALL assert done in WB: ALU/lui ops 3 cycles after acceptance edge, lw/sw 4 cycles after.
REQ-016 SHALL support opcodes: lui 0x0F (rt=imm<<16), addi 0x08, addiu 0x09, andi 0x0C, ori 0x0D (andi/ori zero-extend, add* sign-extend), lw 0x23, sw 0x2B.
REQ-017 SHALL support R-type (opcode 0x00) funct: add 0x20, addu 0x21, sub 0x22, and 0x24, or 0x25, slt 0x2A (signed), sll 0x00, srl 0x02 (shamt field); write rd.
REQ-018 SHALL compute effective address rs+sext(imm) mod 2^32; word index = EA[ $clog2(DMEM_DEPTH)+1 : 2 ] (wrap-around, upper bits ignored).
REQ-019 SHALL, on misaligned lw/sw, perform no memory or GPR write and pulse err_align.
REQ-020 SHALL, on illegal instruction, perform no state write and pulse err_illegal; FSM skips MEM.
REQ-021 SHALL discard every write to register 0; GPR[0] reads 0.
REQ-022 SHALL treat register fields >= NUM_GPR as illegal (err_illegal).
REQ-023 SHALL write GPR/memory only in WB (sw writes memory in MEM).

Reset
REQ-024 SHALL, when rst_n=0 at a clock edge, clear all GPRs, all data memory words, FSM to IDLE, done/err_*=0; instr_ready=1 on the first cycle after release.
REQ-025 SHALL abandon an in-flight instruction on reset with no writeback and no done pulse.

Configuration
REQ-026 SHALL, with MIPS_OVF_TRAP_EN defined, treat signed overflow in add/addi/sub as a trap: no GPR write, err_illegal pulses with done.
REQ-027 SHALL, without MIPS_OVF_TRAP_EN, wrap add/addi/sub results modulo 2^32 exactly like addu/addiu.

Structure
REQ-028 SHALL take opcode/funct constants, FSM state enum and decoded-op typedef from shared package mips_pkg.
REQ-029 SHALL place arithmetic/logic/shift/overflow detection in sub-module mips_alu (combinational, 32-bit operands, op select, result, ovf).

Verification
REQ-030 SHALL cover: lui, rs=0, rt=11, imm=1000 -> 3 cycles later done; GPR[11]=0x03E80000.
REQ-031 SHALL cover: ori R1=R0|0x0010; sw R1 -> [R0+12]; lw R14 <- [R0+12] -> dmem[3]=0x10, GPR[14]=0x10, lw done 4 cycles after acceptance.
REQ-032 SHALL cover: lui R2=0x7FFF0000, ori R2|=0xFFFF, add R3=R2+R2 -> with MIPS_OVF_TRAP_EN R3 stays 0 and err_illegal pulses; without, R3=0xFFFFFFFE.
REQ-033 SHALL cover: lw with EA=0x6 -> err_align pulses, target GPR unchanged; opcode 0x3F -> err_illegal, no writes.
REQ-034 SHALL cover: addi R0=R0+5 -> GPR[0] remains 0; instr_valid held high in DECODE with a different word -> ignored.
REQ-035 SHALL cover: rst_n low during EXEC of addi R4=R0+7 -> no done, GPR[4]=0, instr_ready=1 the cycle after release.
